// File: rtl/hcsr04_pkg.sv
// Shared state encodings and default timing constants for the multi-channel
// HC-SR04 scanner (defaults assume a 50 MHz clk).
package hcsr04_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_TRIG      = 4'd1,
        ST_ESPERA    = 4'd2,
        ST_MEDE      = 4'd3,
        ST_ARMAZENA  = 4'd4,
        ST_INTERVALO = 4'd5
    } estado_t;

    localparam int DEF_NUM_CH         = 4;
    localparam int DEF_TRIG_CYCLES    = 500;
    localparam int DEF_CM_CYCLES      = 2941;
    localparam int DEF_TIMEOUT_CYCLES = 100000000;
    localparam int DEF_GAP_CYCLES     = 3000000;
    localparam int DEF_DIST_W         = 12;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Largest legal distance code; all ones is kept free for the timeout marker.
    function automatic int dist_sat(input int w);
        return (1 << w) - 2;
    endfunction

endpackage

// File: rtl/contador_cm_arred.sv
// Echo-width to centimetre counter: per-cm cycle prescaler, half-cm round-up
// and saturation just below the timeout code.
module contador_cm_arred
    import hcsr04_pkg::*;
#(
    parameter int CM_CYCLES = DEF_CM_CYCLES,
    parameter int DIST_W    = DEF_DIST_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_clr,
    input  logic              i_en,
    output logic [DIST_W-1:0] o_dist
);

    localparam int SUB_W = (CM_CYCLES > 1) ? $clog2(CM_CYCLES) : 1;
    localparam logic [SUB_W-1:0]  SUB_LAST = SUB_W'(CM_CYCLES - 1);
    localparam logic [SUB_W-1:0]  SUB_HALF = SUB_W'(CM_CYCLES / 2);
    localparam logic [DIST_W-1:0] CM_MAX   = DIST_W'(dist_sat(DIST_W));

    logic [SUB_W-1:0]  r_sub;
    logic [DIST_W-1:0] r_cm;
    logic              w_round;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sub <= '0;
            r_cm  <= '0;
        end else if (i_clr) begin
            r_sub <= '0;
            r_cm  <= '0;
        end else if (i_en) begin
            if (r_sub == SUB_LAST) begin
                r_sub <= '0;
                if (r_cm != CM_MAX)
                    r_cm <= r_cm + 1'b1;
            end else begin
                r_sub <= r_sub + 1'b1;
            end
        end
    end

    // A single-cycle prescaler has no fractional part, so never round.
    assign w_round = (CM_CYCLES > 1) && (r_sub >= SUB_HALF);
    assign o_dist  = (w_round && (r_cm != CM_MAX)) ? r_cm + 1'b1 : r_cm;

endmodule

// File: rtl/interface_hcsr04_multi.sv
// Round-robin HC-SR04 scanner: triggers each sensor in turn, times its echo
// and publishes a per-channel distance in cm with a one-cycle ready strobe.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// IDLE         | waiting for medir; channel pointer parked
// TRIG         | trigger[ch] high for TRIG_CYCLES clocks
// ESPERA       | waiting for a clean low-to-high echo edge, timeout running
// MEDE         | echo high, cm counter running, timeout still running
// ARMAZENA     | one clock: latch canal/distancia/timeout, pronto next clock
// INTERVALO    | GAP_CYCLES quiet time, then next channel / wrap / IDLE
module interface_hcsr04_multi
    import hcsr04_pkg::*;
#(
    parameter int  NUM_CH         = DEF_NUM_CH,
    parameter int  TRIG_CYCLES    = DEF_TRIG_CYCLES,
    parameter int  CM_CYCLES      = DEF_CM_CYCLES,
    parameter int  TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int  GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int  DIST_W         = DEF_DIST_W,
    localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              medir,
    input  logic              continuo,
    input  logic [NUM_CH-1:0] echo,
    output logic [NUM_CH-1:0] trigger,
    output logic [CH_W-1:0]   canal,
    output logic [DIST_W-1:0] distancia,
    output logic              timeout,
    output logic              pronto,
    output logic              ocupado,
    output logic [3:0]        db_estado
);

    localparam int TMR_W = $clog2(max3(TRIG_CYCLES, TIMEOUT_CYCLES, GAP_CYCLES) + 1);
    localparam logic [TMR_W-1:0]  TRIG_LOAD = TMR_W'(TRIG_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TMO_LOAD  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0]  GAP_LOAD  = TMR_W'(GAP_CYCLES - 1);
    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);
    localparam logic [NUM_CH-1:0] TRIG_CH0  = NUM_CH'(1);

    estado_t           r_state;
    logic [CH_W-1:0]   r_ch;
    logic [TMR_W-1:0]  r_timer;
    logic [NUM_CH-1:0] r_echo_s1;
    logic [NUM_CH-1:0] r_echo_s2;
    logic              r_echo_prev;
    logic              r_tmo_flag;
    logic [NUM_CH-1:0] r_trigger;
    logic [CH_W-1:0]   r_canal;
    logic [DIST_W-1:0] r_distancia;
    logic              r_timeout;
    logic              r_pronto;

    logic              w_echo_ch;
    logic              w_rise;
    logic              w_fall;
    logic              w_tc;
    logic              w_cnt_clr;
    logic              w_cnt_en;
    logic [DIST_W-1:0] w_dist;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_echo_s1 <= '0;
            r_echo_s2 <= '0;
        end else begin
            r_echo_s1 <= echo;
            r_echo_s2 <= r_echo_s1;
        end
    end

    assign w_echo_ch = r_echo_s2[r_ch];
    assign w_rise    = w_echo_ch && !r_echo_prev;
    assign w_fall    = !w_echo_ch && r_echo_prev;
    assign w_tc      = (r_timer == '0);

    // The rising-edge cycle is counted so the count equals the echo width.
    assign w_cnt_clr = (r_state == ST_TRIG);
    assign w_cnt_en  = ((r_state == ST_ESPERA) && w_rise) ||
                       ((r_state == ST_MEDE) && w_echo_ch);

    contador_cm_arred #(
        .CM_CYCLES (CM_CYCLES),
        .DIST_W    (DIST_W)
    ) u_contador (
        .clock  (clock),
        .reset  (reset),
        .i_clr  (w_cnt_clr),
        .i_en   (w_cnt_en),
        .o_dist (w_dist)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_ch        <= '0;
            r_timer     <= '0;
            r_echo_prev <= 1'b0;
            r_tmo_flag  <= 1'b0;
            r_trigger   <= '0;
            r_canal     <= '0;
            r_distancia <= '0;
            r_timeout   <= 1'b0;
            r_pronto    <= 1'b0;
        end else begin
            r_pronto    <= 1'b0;
            r_echo_prev <= w_echo_ch;
            case (r_state)
                ST_IDLE: begin
                    if (medir) begin
                        r_ch      <= '0;
                        r_trigger <= TRIG_CH0;
                        r_timer   <= TRIG_LOAD;
                        r_state   <= ST_TRIG;
                    end
                end
                ST_TRIG: begin
                    if (w_tc) begin
                        r_trigger   <= '0;
                        r_timer     <= TMO_LOAD;
                        r_tmo_flag  <= 1'b0;
                        // Pretend the line was already high so a level present
                        // at entry is never mistaken for an edge.
                        r_echo_prev <= 1'b1;
                        r_state     <= ST_ESPERA;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                ST_ESPERA: begin
                    if (w_tc) begin
                        r_tmo_flag <= 1'b1;
                        r_state    <= ST_ARMAZENA;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                        if (w_rise)
                            r_state <= ST_MEDE;
                    end
                end
                ST_MEDE: begin
                    if (w_tc) begin
                        r_tmo_flag <= 1'b1;
                        r_state    <= ST_ARMAZENA;
                    end else if (w_fall) begin
                        r_state <= ST_ARMAZENA;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                ST_ARMAZENA: begin
                    r_canal     <= r_ch;
                    r_distancia <= r_tmo_flag ? {DIST_W{1'b1}} : w_dist;
                    r_timeout   <= r_tmo_flag;
                    r_pronto    <= 1'b1;
                    r_timer     <= GAP_LOAD;
                    r_state     <= ST_INTERVALO;
                end
                ST_INTERVALO: begin
                    if (!w_tc) begin
                        r_timer <= r_timer - 1'b1;
                    end else if (r_ch != LAST_CH) begin
                        r_ch      <= r_ch + 1'b1;
                        r_trigger <= TRIG_CH0 << (r_ch + 1'b1);
                        r_timer   <= TRIG_LOAD;
                        r_state   <= ST_TRIG;
                    end else if (continuo) begin
                        r_ch      <= '0;
                        r_trigger <= TRIG_CH0;
                        r_timer   <= TRIG_LOAD;
                        r_state   <= ST_TRIG;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_trigger <= '0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign trigger   = r_trigger;
    assign canal     = r_canal;
    assign distancia = r_distancia;
    assign timeout   = r_timeout;
    assign pronto    = r_pronto;
    assign ocupado   = (r_state != ST_IDLE);
    assign db_estado = r_state;

endmodule

// File: tb/tb_interface_hcsr04_multi.sv
// Self-checking bench for interface_hcsr04_multi: directed vector table,
// randomized scans against an arithmetic reference model, and corner sequences.
module tb_interface_hcsr04_multi;

    localparam int NUM_CH         = 2;
    localparam int TRIG_CYCLES    = 5;
    localparam int CM_CYCLES      = 10;
    localparam int TIMEOUT_CYCLES = 200;
    localparam int GAP_CYCLES     = 4;
    localparam int DIST_W         = 8;
    localparam int TIMEOUT_SAT    = 5000;

    logic       clock = 1'b0;
    logic       reset, medir, continuo;
    logic [1:0] echo;
    logic [1:0] trigger;
    logic       canal;
    logic [7:0] distancia;
    logic       timeout, pronto, ocupado;
    logic [3:0] db_estado;

    logic       reset2, medir2;
    logic [1:0] trigger2;
    logic       canal2;
    logic [7:0] distancia2;
    logic       timeout2, pronto2, ocupado2;
    logic [3:0] db_estado2;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    interface_hcsr04_multi #(
        .NUM_CH(NUM_CH), .TRIG_CYCLES(TRIG_CYCLES), .CM_CYCLES(CM_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .GAP_CYCLES(GAP_CYCLES), .DIST_W(DIST_W)
    ) dut (
        .clock(clock), .reset(reset), .medir(medir), .continuo(continuo),
        .echo(echo), .trigger(trigger), .canal(canal), .distancia(distancia),
        .timeout(timeout), .pronto(pronto), .ocupado(ocupado), .db_estado(db_estado)
    );

    interface_hcsr04_multi #(
        .NUM_CH(NUM_CH), .TRIG_CYCLES(TRIG_CYCLES), .CM_CYCLES(CM_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_SAT), .GAP_CYCLES(GAP_CYCLES), .DIST_W(DIST_W)
    ) dut_sat (
        .clock(clock), .reset(reset2), .medir(medir2), .continuo(continuo),
        .echo(echo), .trigger(trigger2), .canal(canal2), .distancia(distancia2),
        .timeout(timeout2), .pronto(pronto2), .ocupado(ocupado2), .db_estado(db_estado2)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: width in clocks -> cm with half-cm round-up, clamped below
    // the all-ones timeout code; width 0 means the echo never arrives.
    function automatic void model(input int n, output int d, output int t);
        int q;
        if (n == 0) begin
            d = 255;
            t = 1;
        end else begin
            q = n / CM_CYCLES;
            if ((n % CM_CYCLES) >= CM_CYCLES / 2) q = q + 1;
            if (q > 254) q = 254;
            d = q;
            t = 0;
        end
    endfunction

    int   trig_len [2];
    int   pronto_cnt = 0;
    int   pronto_double = 0;
    int   overlap_cnt = 0;
    logic pronto_q = 1'b0;

    always @(negedge clock) begin
        if (trigger[0] && trigger[1]) overlap_cnt++;
        for (int c = 0; c < 2; c++) begin
            if (trigger[c]) begin
                trig_len[c]++;
            end else if (trig_len[c] != 0) begin
                check($sformatf("trig_width_ch%0d", c), trig_len[c], TRIG_CYCLES);
                trig_len[c] = 0;
            end
        end
        if (pronto) pronto_cnt++;
        if (pronto && pronto_q) pronto_double++;
        pronto_q = pronto;
    end

    task automatic tick(input int k);
        repeat (k) @(posedge clock);
        #1;
    endtask

    task automatic start_scan();
        medir = 1'b1;
        tick(1);
        medir = 1'b0;
    endtask

    // Waits for trigger[ch] to complete, then answers with an n-clock echo
    // after dly clocks (n == 0: no echo at all).
    task automatic serve(input int ch, input int dly, input int n);
        int b;
        b = 0;
        while (!trigger[ch] && b < 100) begin tick(1); b++; end
        check($sformatf("trig_seen_ch%0d", ch), int'(trigger[ch]), 1);
        check($sformatf("trig_onehot_ch%0d", ch), int'(trigger), 1 << ch);
        b = 0;
        while (trigger[ch] && b < 100) begin tick(1); b++; end
        if (n > 0) begin
            if (dly > 0) tick(dly);
            echo[ch] = 1'b1;
            tick(n);
            echo[ch] = 1'b0;
        end
    endtask

    int exp_pronto = 0;

    task automatic wait_pronto(input string name, input int ch, input int d, input int t,
                               output int lat);
        int b;
        b = 0;
        while (!pronto && b < 400) begin tick(1); b++; end
        lat = b;
        exp_pronto++;
        check({name, "_pronto"}, int'(pronto), 1);
        check({name, "_canal"}, int'(canal), ch);
        check({name, "_dist"}, int'(distancia), d);
        check({name, "_tmo"}, int'(timeout), t);
    endtask

    task automatic check_idle(input string name);
        tick(GAP_CYCLES + 2);
        check({name, "_ocupado"}, int'(ocupado), 0);
        check({name, "_estado"}, int'(db_estado), 0);
    endtask

    typedef struct {
        int ch;
        int dly;
        int n;
        int d;
        int t;
    } vec_t;

    vec_t vt [8];

    initial begin
        int lat, d, t, n, dly, pc_before, b;

        vt[0] = '{0, 2, 47, 5, 0};
        vt[1] = '{1, 3, 45, 5, 0};
        vt[2] = '{0, 1, 44, 4, 0};
        vt[3] = '{1, 0, 0, 255, 1};
        vt[4] = '{0, 4, 1, 0, 0};
        vt[5] = '{1, 2, 5, 1, 0};
        vt[6] = '{0, 0, 10, 1, 0};
        vt[7] = '{1, 5, 14, 1, 0};

        reset = 1'b1; reset2 = 1'b1;
        medir = 1'b0; medir2 = 1'b0; continuo = 1'b0; echo = 2'b00;
        tick(3);
        check("rst_trigger", int'(trigger), 0);
        check("rst_canal", int'(canal), 0);
        check("rst_dist", int'(distancia), 0);
        check("rst_tmo", int'(timeout), 0);
        check("rst_pronto", int'(pronto), 0);
        check("rst_ocupado", int'(ocupado), 0);
        check("rst_estado", int'(db_estado), 0);
        reset = 1'b0; reset2 = 1'b0;
        tick(2);

        for (int i = 0; i < 8; i++) begin
            if (vt[i].ch == 0) start_scan();
            serve(vt[i].ch, vt[i].dly, vt[i].n);
            wait_pronto($sformatf("vec%0d", i), vt[i].ch, vt[i].d, vt[i].t, lat);
            if (vt[i].n == 0) check($sformatf("vec%0d_tmo_latency", i), lat, TIMEOUT_CYCLES + 1);
            if (vt[i].ch == 1) check_idle($sformatf("vec%0d_idle", i));
        end

        for (int s = 0; s < 20; s++) begin
            start_scan();
            for (int c = 0; c < 2; c++) begin
                n   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 150));
                dly = int'($urandom_range(0, 20));
                model(n, d, t);
                serve(c, dly, n);
                wait_pronto($sformatf("rnd%0d_ch%0d_n%0d", s, c, n), c, d, t, lat);
            end
            check_idle($sformatf("rnd%0d_idle", s));
        end

        // Echo already high when the wait for the edge begins.
        start_scan();
        b = 0;
        while (!trigger[0] && b < 100) begin tick(1); b++; end
        echo[0] = 1'b1;
        b = 0;
        while (trigger[0] && b < 100) begin tick(1); b++; end
        tick(3);
        echo[0] = 1'b0;
        tick(3);
        echo[0] = 1'b1;
        tick(25);
        echo[0] = 1'b0;
        wait_pronto("prehigh", 0, 3, 0, lat);
        serve(1, 1, 12);
        wait_pronto("prehigh_ch1", 1, 1, 0, lat);
        check_idle("prehigh_idle");

        continuo = 1'b1;
        start_scan();
        serve(0, 2, 30); wait_pronto("cont0", 0, 3, 0, lat);
        serve(1, 2, 30); wait_pronto("cont1", 1, 3, 0, lat);
        serve(0, 2, 30); wait_pronto("cont2", 0, 3, 0, lat);
        continuo = 1'b0;
        serve(1, 2, 30); wait_pronto("cont3", 1, 3, 0, lat);
        check_idle("cont_idle");

        // Reset in the middle of an echo measurement.
        start_scan();
        b = 0;
        while (!trigger[0] && b < 100) begin tick(1); b++; end
        b = 0;
        while (trigger[0] && b < 100) begin tick(1); b++; end
        echo[0] = 1'b1;
        tick(6);
        check("pre_rst_mede", int'(db_estado), 3);
        pc_before = pronto_cnt;
        #2 reset = 1'b1;
        #1;
        check("midrst_trigger", int'(trigger), 0);
        check("midrst_canal", int'(canal), 0);
        check("midrst_dist", int'(distancia), 0);
        check("midrst_tmo", int'(timeout), 0);
        check("midrst_pronto", int'(pronto), 0);
        check("midrst_ocupado", int'(ocupado), 0);
        check("midrst_estado", int'(db_estado), 0);
        tick(2);
        echo[0] = 1'b0;
        reset = 1'b0;
        tick(10);
        check("midrst_no_pronto", pronto_cnt, pc_before);
        start_scan();
        serve(0, 1, 47); wait_pronto("post_rst0", 0, 5, 0, lat);
        serve(1, 1, 20); wait_pronto("post_rst1", 1, 2, 0, lat);
        check_idle("post_rst_idle");

        // Saturation on the long-timeout instance.
        medir2 = 1'b1;
        tick(1);
        medir2 = 1'b0;
        b = 0;
        while (!trigger2[0] && b < 100) begin tick(1); b++; end
        b = 0;
        while (trigger2[0] && b < 100) begin tick(1); b++; end
        tick(2);
        echo[0] = 1'b1;
        tick(3000);
        echo[0] = 1'b0;
        b = 0;
        while (!pronto2 && b < 200) begin tick(1); b++; end
        model(3000, d, t);
        check("sat_pronto", int'(pronto2), 1);
        check("sat_canal", int'(canal2), 0);
        check("sat_dist", int'(distancia2), d);
        check("sat_tmo", int'(timeout2), t);
        reset2 = 1'b1;
        tick(2);

        check("pronto_count", pronto_cnt, exp_pronto);
        check("pronto_single_cycle", pronto_double, 0);
        check("trigger_overlap", overlap_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/interface_hcsr04_multi.md
INTERFACE_HCSR04_MULTI -- requirements
Module: interface_hcsr04_multi

Interface
REQ-001 The module SHALL have parameter NUM_CH, default 4: number of HC-SR04 sensors scanned.
REQ-002 The module SHALL have parameter TRIG_CYCLES, default 500: trigger pulse width in clocks (10 us at 50 MHz).
REQ-003 The module SHALL have parameter CM_CYCLES, default 2941: echo clocks per centimetre.
REQ-004 The module SHALL have parameter TIMEOUT_CYCLES, default 100000000: echo timeout in clocks (2 s).
REQ-005 The module SHALL have parameter GAP_CYCLES, default 3000000: idle clocks between channels (60 ms anti-crosstalk).
REQ-006 The module SHALL have parameter DIST_W, default 12: binary distance width in cm.
REQ-007 The module SHALL have port clock, input, 1 bit: single system clock, all logic on its rising edge.
REQ-008 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-009 The module SHALL have port medir, input, 1 bit: start-scan request, sampled in IDLE only.
REQ-010 The module SHALL have port continuo, input, 1 bit: 1 = wrap to channel 0 after the last channel, 0 = single scan.
REQ-011 The module SHALL have port echo, input, NUM_CH bits: asynchronous echo lines.
REQ-012 The module SHALL have port trigger, output, NUM_CH bits: per-sensor trigger, at most one bit high at a time.
REQ-013 The module SHALL have port canal, output, clog2(NUM_CH) bits: channel of the current result.
REQ-014 The module SHALL have port distancia, output, DIST_W bits: registered distance in cm.
REQ-015 The module SHALL have port timeout, output, 1 bit: registered flag marking the current result as timed out.
REQ-016 The module SHALL have port pronto, output, 1 bit: one-cycle strobe when canal/distancia/timeout update.
REQ-017 The module SHALL have port ocupado, output, 1 bit: high in every state except IDLE.
REQ-018 The module SHALL have port db_estado, output, 4 bits: FSM state encoding for debug displays.

Function
REQ-019 The FSM SHALL use states IDLE, TRIG, ESPERA (wait echo rise), MEDE (echo high), ARMAZENA, INTERVALO.
REQ-020 IDLE -> TRIG on medir=1, with channel index set to 0; medir SHALL be ignored in all other states.
REQ-021 In TRIG, trigger[ch] SHALL be high for exactly TRIG_CYCLES consecutive clocks, then the FSM SHALL go to ESPERA.
REQ-022 echo SHALL pass through a 2-flop synchroniser; all echo decisions SHALL use the synchronised bit of the current channel only.
REQ-023 The timeout counter SHALL clear on entry to ESPERA and count in ESPERA and MEDE; reaching TIMEOUT_CYCLES SHALL force ARMAZENA with timeout=1 and distancia set to all ones.
REQ-024 ESPERA -> MEDE on a synchronised echo rise.
REQ-025 In MEDE, a sub-counter SHALL wrap at CM_CYCLES-1 and increment the cm counter on each wrap.
REQ-026 MEDE -> ARMAZENA on a synchronised echo fall.
REQ-027 On echo fall, the result SHALL round up by 1 cm when the sub-counter is >= CM_CYCLES/2.
REQ-028 The cm result SHALL saturate at 2^DIST_W-2; all ones is reserved for timeout.
REQ-029 ARMAZENA SHALL last one clock and load canal/distancia/timeout; pronto SHALL be high in the following clock.
REQ-030 INTERVALO SHALL last GAP_CYCLES clocks, then select the next channel: ch<NUM_CH-1 -> ch+1 and TRIG.
REQ-031 After INTERVALO on the last channel, the FSM SHALL wrap to channel 0 and TRIG when continuo=1, else go to IDLE.
REQ-032 continuo SHALL be sampled only at the last-channel decision point.
REQ-033 Echo already high on entry to ESPERA SHALL NOT count as a rise; a full low-to-high transition is required.

Reset
REQ-034 reset SHALL asynchronously force IDLE, trigger=0, canal=0, distancia=0, timeout=0, pronto=0, ocupado=0, all counters 0 and synchronisers 0.
REQ-035 Reset asserted mid-measurement SHALL abort with no pronto; the first post-reset scan SHALL start at channel 0.

Structure
REQ-036 State encodings and default timing constants SHALL live in shared package hcsr04_pkg.
REQ-037 One sub-module SHALL exist: contador_cm_arred, a parametrised cm counter with rounding and saturation (REQ-025, REQ-027, REQ-028); the FSM SHALL stay in the top level.

Verification (NUM_CH=2, TRIG_CYCLES=5, CM_CYCLES=10, TIMEOUT_CYCLES=200, GAP_CYCLES=4, DIST_W=8)
REQ-038 medir pulse, ch0 echo high 47 clocks -> trigger[0] high exactly 5 clocks, canal=0, distancia=5, timeout=0, one pronto.
REQ-039 ch0 echo high 44 clocks -> distancia=4 (no round-up).
REQ-040 ch1 echo never rises -> canal=1, distancia=8'hFF, timeout=1 after 200 clocks, then IDLE with continuo=0.
REQ-041 continuo=1, both channels echo 30 clocks -> pronto sequence ch0,ch1,ch0 with distancia=3 each; trigger bits never overlap.
REQ-042 echo high 3000 clocks with TIMEOUT_CYCLES raised to 5000 -> distancia=254 (saturated), timeout=0.
REQ-043 reset asserted during MEDE -> all outputs 0 the same cycle; next medir restarts at canal 0.
